mv_avg_mc: RTL and testbench
============================

Name: mv_avg_mc

Overview:
Multi-channel moving-average filter with a window length selectable at runtime as a power of two, up to a compile-time maximum. It is the successor of the single-channel fixed-window averager used for RSSI and IQ power smoothing in the xpu. Each channel keeps its own circular history buffer and running total; no vendor FIFO macro is used. A synchronous flush restarts averaging when the window length changes or software requests it.

Parameters:
DATA_WIDTH, 16, signed sample width per channel
NUM_CH, 2, number of independent channels sharing one valid strobe
LOG2_MAX_LEN, 6, log2 of the maximum window length; history depth per channel is 2^LOG2_MAX_LEN

Ports:
clk  input  1  clock
rstn  input  1  synchronous active-low reset
log2_len  input  $clog2(LOG2_MAX_LEN+1)  window length = 2^log2_len; values above LOG2_MAX_LEN are clamped to LOG2_MAX_LEN
clear  input  1  synchronous flush request, one-cycle pulse
data_in  input  NUM_CH*DATA_WIDTH  packed signed samples; channel k occupies bits [k*DATA_WIDTH +: DATA_WIDTH]
data_in_valid  input  1  sample strobe for all channels
data_out  output  NUM_CH*DATA_WIDTH  packed signed averages, same packing as data_in
data_out_valid  output  1  one-cycle pulse per accepted sample
window_full  output  1  high when the history holds a full window

Behaviour:
- Reset: rstn is synchronous and active-low; the clock is clk. While rstn=0:
  - All running totals, the write pointer, fill count, data_out_valid and window_full go to 0.
  - data_out reads 0.
  - The latched log2_len (len_q) takes the value of log2_len after clamping.
  - History contents are don't-care; they are never read before being written after a flush.
- Accumulator: each channel's total is DATA_WIDTH+LOG2_MAX_LEN bits, signed. No saturation is needed, since overflow is impossible by construction.
- State per block (not per channel):
  - FILL: count < 2^len_q.
  - RUN: count == 2^len_q.
  - window_full = (state == RUN).
- Accepted sample (data_in_valid=1, no flush this cycle):
  - Write each channel's sample to hist[k][wr_ptr]. wr_ptr increments modulo 2^LOG2_MAX_LEN.
  - Read oldest = hist[k][(wr_ptr - 2^len_q) mod depth]. This is a read-before-write; when len_q = LOG2_MAX_LEN it is the same address as the write.
  - FILL: total += x, count += 1. Transition to RUN when count reaches 2^len_q.
  - RUN: total += x - oldest.
- Output:
  - data_out[k] = total[k] >>> len_q (arithmetic shift, floor), truncated to DATA_WIDTH. It is driven from the total registers and stays stable between pulses.
  - data_out_valid pulses in the cycle after acceptance, so latency is 1 cycle.
  - During FILL the partial sum is still divided by the full window, giving a ramp-up.
- data_in_valid=0: no state change; data_out holds.
- Flush. A flush occurs when clear=1, or when the clamped log2_len != len_q.
  - Next cycle: totals=0, count=0, state=FILL, len_q=new log2_len, data_out_valid=0.
  - Any sample presented in the flush cycle is discarded.
  - Flush has priority over data_in_valid. wr_ptr is not reset.
- log2_len=0: window of 1. After the first sample, state is RUN and the output equals the previous input.
- Back-to-back valid strobes every cycle are supported at full rate.

Optional Feature:
- Macro MV_AVG_MC_ROUND_EN.
- Defined: data_out[k] = (total[k] + (len_q>0 ? 2^(len_q-1) : 0)) >>> len_q, i.e. round-half-up. The addition is done at accumulator width plus 1 bit.
- Undefined: plain floor truncation as described in Behaviour.

Test Plan:
- NUM_CH=2, log2_len=2, ch0=100 and ch1=-100 every cycle -> ch0 outputs 25,50,75,100,100...; ch1 outputs -25,-50,-75,-100...; window_full rises with the 4th output; each output lags its input by 1 cycle.
- Window-length change: log2_len=2 in RUN with ch0=100, then log2_len=3 -> no output in the flush cycle and that sample is dropped; next outputs are 12,25,37,50,...,100 after 8 samples.
- Clear mid-RUN, with data_in_valid held high in the same cycle -> no valid that cycle; totals restart from 0; first output 25 for the log2_len=2 stream.
- Rounding with log2_len=2, input 1,1,1,1 -> without macro 0,0,0,1; with MV_AVG_MC_ROUND_EN 0,1,1,1. Input -1 once -> -1 (floor) / 0 (rounded).
- Extremes with LOG2_MAX_LEN=6, log2_len=6, ch0=-32768 and ch1=32767 for 70 samples -> steady state -32768 / 32767 with no wrap; window_full after the 64th sample.
- Reset pulse mid-RUN with gapped valid strobes (valid every 3rd cycle) -> all outputs 0, window_full=0; averaging restarts cleanly and output pulses only follow valid strobes.

Source files
------------

// File: rtl/mv_avg_mc.sv
// mv_avg_mc: multi-channel moving-average filter.
//
// Every channel keeps its own circular history of the last 2^LOG2_MAX_LEN
// samples and a running total. The active window is 2^len_q samples, with
// len_q latched from log2_len. Any change of the (clamped) window length, or
// a clear pulse, flushes the filter: totals and the fill count restart from
// zero. The write pointer keeps running, so no history is ever reset.
//
// Optional build macro:
//   MV_AVG_MC_ROUND_EN - round half up on the output division instead of
//                        floor truncation.
//
// Reset (rstn) is synchronous and active-low.

module mv_avg_mc #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CH       = 2,
  parameter int LOG2_MAX_LEN = 6
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic [$clog2(LOG2_MAX_LEN+1)-1:0]  log2_len,
  input  logic                               clear,
  input  logic [NUM_CH*DATA_WIDTH-1:0]       data_in,
  input  logic                               data_in_valid,
  output logic [NUM_CH*DATA_WIDTH-1:0]       data_out,
  output logic                               data_out_valid,
  output logic                               window_full
);

  localparam int LEN_W = $clog2(LOG2_MAX_LEN + 1);
  localparam int DEPTH = 1 << LOG2_MAX_LEN;
  localparam int PTR_W = LOG2_MAX_LEN;
  localparam int CNT_W = LOG2_MAX_LEN + 1;
  // A sum of 2^LOG2_MAX_LEN samples of DATA_WIDTH bits cannot leave this range.
  localparam int ACC_W = DATA_WIDTH + LOG2_MAX_LEN;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(LOG2_MAX_LEN);

  typedef enum logic {
    ST_FILL,  // fewer than 2^len_q samples accepted since the last flush
    ST_RUN    // a complete window is held; the oldest sample drops out
  } state_e;

  // Sign-extends a sample to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext(input logic signed [DATA_WIDTH-1:0] x);
    return {{LOG2_MAX_LEN{x[DATA_WIDTH-1]}}, x};
  endfunction

  // ---------------------------------------------------------------------------
  // Shared control state
  // ---------------------------------------------------------------------------
  state_e            state_q, state_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;

  logic [LEN_W-1:0]  len_clamped;
  logic [CNT_W-1:0]  win_len;
  logic [CNT_W-1:0]  count_inc;
  logic [PTR_W-1:0]  rd_ptr;
  logic              flush;
  logic              accept;

  assign len_clamped = (log2_len > MAX_LEN) ? MAX_LEN : log2_len;
  assign win_len     = CNT_W'(1) << len_q;
  assign count_inc   = count_q + CNT_W'(1);

  // The oldest sample in the window sits 2^len_q entries behind the write
  // pointer. For the maximum window the low bits of win_len are all zero, so
  // the read address equals the write address; the read still returns the old
  // entry because the write only lands at the clock edge.
  assign rd_ptr = wr_ptr_q - win_len[PTR_W-1:0];

  // A window-length change restarts averaging just like an explicit clear.
  assign flush  = clear || (len_clamped != len_q);
  assign accept = rstn && data_in_valid && !flush;

  // Next-state logic: flush beats a sample strobe; the fill count saturates at
  // the window length by moving to RUN.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d  = state_q;
    len_d    = len_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    valid_d  = 1'b0;

    if (flush) begin
      state_d = ST_FILL;
      len_d   = len_clamped;
      count_d = '0;
    end else if (data_in_valid) begin
      valid_d  = 1'b1;
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      case (state_q)
        ST_FILL: begin
          count_d = count_inc;
          if (count_inc == win_len) begin
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          count_d = count_q;
        end
        default: begin
          state_d = ST_FILL;
          count_d = '0;
        end
      endcase
    end
  end

  // Control registers; len_q tracks the clamped input while in reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rstn) begin
      state_q  <= ST_FILL;
      len_q    <= len_clamped;
      wr_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  assign data_out_valid = valid_q;
  assign window_full    = (state_q == ST_RUN);

  // ---------------------------------------------------------------------------
  // Per-channel history, running total and output scaling
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] hist_q [DEPTH];
    logic signed [DATA_WIDTH-1:0] sample;
    logic signed [DATA_WIDTH-1:0] oldest;
    logic signed [ACC_W-1:0]      total_q, total_d;

    assign sample = data_in[k*DATA_WIDTH +: DATA_WIDTH];
    assign oldest = hist_q[rd_ptr];

    // History write: one entry per accepted sample.
    always_ff @(posedge clk) begin
      // NOTE: the history array has no reset. After a flush the fill count
      // guarantees that no entry is read before it has been rewritten.
      if (accept) begin
        hist_q[wr_ptr_q] <= sample;
      end
    end

    // Running total: add the new sample and, once the window is full, drop the oldest.
    always_comb begin
      total_d = total_q;
      if (flush) begin
        total_d = '0;
      end else if (data_in_valid) begin
        if (state_q == ST_RUN) begin
          total_d = total_q + sext(sample) - sext(oldest);
        end else begin
          total_d = total_q + sext(sample);
        end
      end
    end

    // Total register; cleared on reset.
    always_ff @(posedge clk) begin
      if (!rstn) begin
        total_q <= '0;
      end else begin
        total_q <= total_d;
      end
    end

`ifdef MV_AVG_MC_ROUND_EN
    // Round half up: add 2^(len_q-1) (zero for a window of one) with one guard
    // bit so that the addition cannot wrap, then shift.
    logic signed [ACC_W:0] total_ext;
    logic signed [ACC_W:0] half;
    logic signed [ACC_W:0] rounded;

    assign total_ext = {total_q[ACC_W-1], total_q};
    assign half      = ((ACC_W+1)'(1) << len_q) >> 1;
    assign rounded   = total_ext + half;

    assign data_out[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(rounded >>> len_q);
`else
    // Floor division by the window length. During FILL the partial sum is
    // still divided by the full window, which gives the ramp-up.
    assign data_out[k*DATA_WIDTH +: DATA_WIDTH] = DATA_WIDTH'(total_q >>> len_q);
`endif
  end

endmodule

// File: tb/tb_mv_avg_mc.sv
// tb_mv_avg_mc: self-checking bench for mv_avg_mc.
//
// The reference model keeps, per channel, a queue of the samples accepted
// since the last flush (at most one window long) and computes the average
// with plain integer arithmetic. Build with MV_AVG_MC_ROUND_EN defined to
// exercise the rounding variant.

module tb_mv_avg_mc;

  localparam int DW     = 16;
  localparam int NUM_CH = 2;
  localparam int LMAX   = 6;
  localparam int LEN_W  = $clog2(LMAX + 1);
  localparam int BUS_W  = NUM_CH * DW;

  logic             clk = 1'b0;
  logic             rstn;
  logic [LEN_W-1:0] log2_len;
  logic             clear;
  logic [BUS_W-1:0] data_in;
  logic             data_in_valid;
  logic [BUS_W-1:0] data_out;
  logic             data_out_valid;
  logic             window_full;

  int n_checks = 0;
  int n_fail   = 0;

  mv_avg_mc #(
    .DATA_WIDTH   (DW),
    .NUM_CH       (NUM_CH),
    .LOG2_MAX_LEN (LMAX)
  ) dut (
    .clk            (clk),
    .rstn           (rstn),
    .log2_len       (log2_len),
    .clear          (clear),
    .data_in        (data_in),
    .data_in_valid  (data_in_valid),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .window_full    (window_full)
  );

  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  int m_len;
  int m_hist [NUM_CH][$];
  bit m_valid;

  function automatic void model_step(input bit rst_n, input bit v, input bit clr,
                                     input int len, input logic [BUS_W-1:0] din);
    int cl;
    cl = (len > LMAX) ? LMAX : len;
    m_valid = 1'b0;
    if (!rst_n || clr || cl != m_len) begin
      for (int k = 0; k < NUM_CH; k++) m_hist[k].delete();
      m_len = cl;
    end else if (v) begin
      for (int k = 0; k < NUM_CH; k++) begin
        logic signed [DW-1:0] s;
        s = din[k*DW +: DW];
        m_hist[k].push_back(int'(s));
        if (m_hist[k].size() > (1 << m_len)) void'(m_hist[k].pop_front());
      end
      m_valid = 1'b1;
    end
  endfunction

  function automatic logic [BUS_W-1:0] model_out();
    logic [BUS_W-1:0] r;
    longint s;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      s = 0;
      for (int i = 0; i < m_hist[k].size(); i++) s += longint'(m_hist[k][i]);
`ifdef MV_AVG_MC_ROUND_EN
      s += (longint'(1) << m_len) >>> 1;
`endif
      s = s >>> m_len;
      r[k*DW +: DW] = s[DW-1:0];
    end
    return r;
  endfunction

  function automatic bit model_full();
    return m_hist[0].size() == (1 << m_len);
  endfunction

  function automatic logic [BUS_W-1:0] pack2(input int a, input int b);
    logic [31:0] ua, ub;
    ua = a;
    ub = b;
    return {ub[DW-1:0], ua[DW-1:0]};
  endfunction

  function automatic logic [BUS_W-1:0] rand_din();
    logic [BUS_W-1:0] r;
    for (int k = 0; k < NUM_CH; k++) r[k*DW +: DW] = DW'($urandom_range(0, 65535));
    return r;
  endfunction

  function automatic int ch(input logic [BUS_W-1:0] bus, input int k);
    logic signed [DW-1:0] s;
    s = bus[k*DW +: DW];
    return int'(s);
  endfunction

  // Drives one cycle of stimulus, advances the model, and returns #1 after the edge.
  task automatic drive_cycle(input bit v, input bit clr, input int len,
                             input logic [BUS_W-1:0] din);
    data_in_valid = v;
    clear         = clr;
    log2_len      = LEN_W'(len);
    data_in       = din;
    model_step(rstn, v, clr, len, din);
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_cycle(1'b1, 1'b0, 2, pack2(123, -77));
      n_checks++;
      if ({data_out_valid, window_full, data_out} !== {1'b0, 1'b0, {BUS_W{1'b0}}}) begin
        n_fail++;
        $display("FAIL reset[%0d]: got valid=%0b full=%0b out=%h, expected all zero",
                 i, data_out_valid, window_full, data_out);
      end
    end
    rstn = 1'b1;
    drive_cycle(1'b0, 1'b0, 2, '0);
    n_checks++;
    if ({data_out_valid, window_full, data_out} !== {1'b0, 1'b0, {BUS_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL reset_release: got valid=%0b full=%0b out=%h, expected all zero",
               data_out_valid, window_full, data_out);
    end
  endtask

  task automatic test_ramp();
    int exp0 [6] = '{25, 50, 75, 100, 100, 100};
    logic [BUS_W-1:0] e;
    for (int i = 0; i < 6; i++) begin
      drive_cycle(1'b1, 1'b0, 2, pack2(100, -100));
      e = model_out();
      n_checks++;
      if ({data_out_valid, window_full, data_out} !== {m_valid, model_full(), e}) begin
        n_fail++;
        $display("FAIL ramp_model[%0d]: got valid=%0b full=%0b out=%h, expected valid=%0b full=%0b out=%h",
                 i, data_out_valid, window_full, data_out, m_valid, model_full(), e);
      end
      n_checks++;
      if (ch(data_out, 0) != exp0[i] || ch(data_out, 1) != -exp0[i] ||
          window_full !== (i >= 3) || data_out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ramp_table[%0d]: got ch0=%0d ch1=%0d full=%0b valid=%0b, expected ch0=%0d ch1=%0d full=%0b valid=1",
                 i, ch(data_out, 0), ch(data_out, 1), window_full, data_out_valid,
                 exp0[i], -exp0[i], (i >= 3));
      end
    end
  endtask

  task automatic test_len_change();
    logic [BUS_W-1:0] e;
    drive_cycle(1'b1, 1'b0, 2, pack2(100, -100));
    // Length change with a sample present: no output, sample dropped.
    drive_cycle(1'b1, 1'b0, 3, pack2(100, -100));
    n_checks++;
    if ({data_out_valid, window_full, data_out} !== {1'b0, 1'b0, {BUS_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL len_change_flush: got valid=%0b full=%0b out=%h, expected valid=0 full=0 out=0",
               data_out_valid, window_full, data_out);
    end
    for (int i = 0; i < 9; i++) begin
      drive_cycle(1'b1, 1'b0, 3, pack2(100, -100));
      e = model_out();
      n_checks++;
      if ({data_out_valid, window_full, data_out} !== {m_valid, model_full(), e}) begin
        n_fail++;
        $display("FAIL len_change[%0d]: got valid=%0b full=%0b out=%h, expected valid=%0b full=%0b out=%h",
                 i, data_out_valid, window_full, data_out, m_valid, model_full(), e);
      end
    end
    n_checks++;
    if (ch(data_out, 0) != 100 || window_full !== 1'b1) begin
      n_fail++;
      $display("FAIL len_change_final: got ch0=%0d full=%0b, expected ch0=100 full=1",
               ch(data_out, 0), window_full);
    end
  endtask

  task automatic test_clear();
    logic [BUS_W-1:0] e;
    for (int i = 0; i < 5; i++) drive_cycle(1'b1, 1'b0, 2, rand_din());
    drive_cycle(1'b1, 1'b1, 2, pack2(100, -100));
    n_checks++;
    if ({data_out_valid, window_full, data_out} !== {1'b0, 1'b0, {BUS_W{1'b0}}}) begin
      n_fail++;
      $display("FAIL clear_cycle: got valid=%0b full=%0b out=%h, expected valid=0 full=0 out=0",
               data_out_valid, window_full, data_out);
    end
    drive_cycle(1'b1, 1'b0, 2, pack2(100, -100));
    e = model_out();
    n_checks++;
    if ({data_out_valid, window_full, data_out} !== {m_valid, model_full(), e} ||
        ch(data_out, 0) != 25) begin
      n_fail++;
      $display("FAIL clear_restart: got valid=%0b full=%0b ch0=%0d, expected valid=1 full=0 ch0=25",
               data_out_valid, window_full, ch(data_out, 0));
    end
  endtask

  task automatic test_rounding();
`ifdef MV_AVG_MC_ROUND_EN
    int exp_ones [4] = '{0, 1, 1, 1};
    int exp_neg = 0;
`else
    int exp_ones [4] = '{0, 0, 0, 1};
    int exp_neg = -1;
`endif
    drive_cycle(1'b0, 1'b1, 2, '0);
    for (int i = 0; i < 4; i++) begin
      drive_cycle(1'b1, 1'b0, 2, pack2(1, 1));
      n_checks++;
      if (ch(data_out, 0) != exp_ones[i] || ch(data_out, 1) != exp_ones[i] ||
          data_out !== model_out()) begin
        n_fail++;
        $display("FAIL rounding_ones[%0d]: got ch0=%0d ch1=%0d, expected %0d",
                 i, ch(data_out, 0), ch(data_out, 1), exp_ones[i]);
      end
    end
    drive_cycle(1'b0, 1'b1, 2, '0);
    drive_cycle(1'b1, 1'b0, 2, pack2(-1, -1));
    n_checks++;
    if (ch(data_out, 0) != exp_neg || ch(data_out, 1) != exp_neg || data_out !== model_out()) begin
      n_fail++;
      $display("FAIL rounding_neg: got ch0=%0d ch1=%0d, expected %0d",
               ch(data_out, 0), ch(data_out, 1), exp_neg);
    end
  endtask

  task automatic test_extremes();
    logic [BUS_W-1:0] e;
    drive_cycle(1'b0, 1'b0, LMAX, '0);
    for (int i = 0; i < 70; i++) begin
      drive_cycle(1'b1, 1'b0, LMAX, pack2(-32768, 32767));
      e = model_out();
      n_checks++;
      if ({data_out_valid, window_full, data_out} !== {m_valid, model_full(), e} ||
          window_full !== (i >= 63)) begin
        n_fail++;
        $display("FAIL extremes[%0d]: got valid=%0b full=%0b out=%h, expected valid=%0b full=%0b out=%h",
                 i, data_out_valid, window_full, data_out, m_valid, (i >= 63), e);
      end
    end
    n_checks++;
    if (ch(data_out, 0) != -32768 || ch(data_out, 1) != 32767) begin
      n_fail++;
      $display("FAIL extremes_steady: got ch0=%0d ch1=%0d, expected -32768 32767",
               ch(data_out, 0), ch(data_out, 1));
    end
  endtask

  task automatic test_len0();
    logic [BUS_W-1:0] d;
    // log2_len=7 clamps to the maximum, so this cycle must not flush.
    drive_cycle(1'b1, 1'b0, 7, pack2(-32768, 32767));
    n_checks++;
    if (data_out_valid !== 1'b1 || data_out !== model_out()) begin
      n_fail++;
      $display("FAIL clamp_no_flush: got valid=%0b out=%h, expected valid=1 out=%h",
               data_out_valid, data_out, model_out());
    end
    drive_cycle(1'b0, 1'b0, 0, '0);
    for (int i = 0; i < 5; i++) begin
      d = rand_din();
      drive_cycle(1'b1, 1'b0, 0, d);
      n_checks++;
      if ({data_out_valid, window_full, data_out} !== {1'b1, 1'b1, d} || data_out !== model_out()) begin
        n_fail++;
        $display("FAIL len0[%0d]: got valid=%0b full=%0b out=%h, expected valid=1 full=1 out=%h",
                 i, data_out_valid, window_full, data_out, d);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    logic [BUS_W-1:0] e;
    bit prev_strobe;
    drive_cycle(1'b0, 1'b0, 2, '0);
    for (int i = 0; i < 15; i++) begin
      drive_cycle((i % 3) == 0, 1'b0, 2, rand_din());
      e = model_out();
      n_checks++;
      if ({data_out_valid, window_full, data_out} !== {m_valid, model_full(), e}) begin
        n_fail++;
        $display("FAIL gapped_pre[%0d]: got valid=%0b full=%0b out=%h, expected valid=%0b full=%0b out=%h",
                 i, data_out_valid, window_full, data_out, m_valid, model_full(), e);
      end
    end
    rstn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive_cycle(1'b1, 1'b0, 2, rand_din());
      n_checks++;
      if ({data_out_valid, window_full, data_out} !== {1'b0, 1'b0, {BUS_W{1'b0}}}) begin
        n_fail++;
        $display("FAIL mid_reset[%0d]: got valid=%0b full=%0b out=%h, expected all zero",
                 i, data_out_valid, window_full, data_out);
      end
    end
    rstn = 1'b1;
    for (int i = 0; i < 18; i++) begin
      prev_strobe = (i % 3) == 0;
      drive_cycle(prev_strobe, 1'b0, 2, rand_din());
      e = model_out();
      n_checks++;
      if ({data_out_valid, window_full, data_out} !== {m_valid, model_full(), e} ||
          data_out_valid !== prev_strobe) begin
        n_fail++;
        $display("FAIL gapped_post[%0d]: got valid=%0b full=%0b out=%h, expected valid=%0b full=%0b out=%h",
                 i, data_out_valid, window_full, data_out, prev_strobe, model_full(), e);
      end
    end
  endtask

  task automatic test_random();
    logic [BUS_W-1:0] e;
    int len;
    bit v, clr;
    len = 3;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 39) == 0) len = $urandom_range(0, 7);
      clr = ($urandom_range(0, 49) == 0);
      v   = ($urandom_range(0, 9) < 7);
      drive_cycle(v, clr, len, rand_din());
      e = model_out();
      n_checks++;
      if ({data_out_valid, window_full, data_out} !== {m_valid, model_full(), e}) begin
        n_fail++;
        $display("FAIL random[%0d]: got valid=%0b full=%0b out=%h, expected valid=%0b full=%0b out=%h",
                 i, data_out_valid, window_full, data_out, m_valid, model_full(), e);
      end
    end
  endtask

  initial begin
    rstn          = 1'b0;
    clear         = 1'b0;
    data_in_valid = 1'b0;
    data_in       = '0;
    log2_len      = LEN_W'(2);
    m_len         = 2;
    m_valid       = 1'b0;
    @(negedge clk);

    test_reset();
    test_ramp();
    test_len_change();
    test_clear();
    test_rounding();
    test_extremes();
    test_len0();
    test_reset_mid_run();
    test_random();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
